// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the memory port arbiter.
package tinker_mem_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 64;
  localparam int MEM_LAT_DEFAULT = 2;
  // Wide enough to count up to the largest legal latency (15).
  localparam int LAT_CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single
// fixed-latency memory. One access is in flight at a time.
//
// Handshake: a requester raises *_req with its address/data stable and holds
// it until *_gnt is seen high in the same cycle; *_gnt is only ever high in
// IDLE and at most one port is granted per cycle. Completion is signalled by a
// one-cycle *_valid pulse; the port's rdata register then holds until that
// port's next load completes.
module mem_port_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);

  state_t                state;
  state_t                state_nxt;
  owner_t                last_owner;
  owner_t                req_owner;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [LAT_CNT_W-1:0]  lat_cnt;
  logic [31:0]           if_rdata_q;
  logic [DATA_W-1:0]     d_rdata_q;
  logic                  grant_if;
  logic                  grant_d;
  logic                  last_wait;

  assign last_wait = (state == ST_WAIT) && (lat_cnt == LAT_LAST);

  // Round-robin arbitration: on a tie the port not served last wins. Gated by
  // reset so no grant is visible while the block is held in reset.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (reset && (state == ST_IDLE)) begin
      if (if_req && d_req) begin
        if (last_owner == OWN_FETCH) grant_d  = 1'b1;
        else                         grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP access sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (if_req || d_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (lat_cnt == LAT_LAST) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, latency counter and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      last_owner <= OWN_FETCH;
    end else begin
      state <= state_nxt;
      if (state == ST_ISSUE)     lat_cnt <= '0;
      else if (state == ST_WAIT) lat_cnt <= lat_cnt + 1'b1;
      if (grant_d)               last_owner <= OWN_DATA;
      else if (grant_if)         last_owner <= OWN_FETCH;
    end
  end

  // Register the winning request; requester inputs are not looked at again
  // until the FSM is back in IDLE. Fetches carry no write data, so zero it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_owner <= OWN_FETCH;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (grant_d) begin
      req_owner <= OWN_DATA;
      req_we    <= d_we;
      req_addr  <= d_addr;
      req_wdata <= d_wdata;
    end else if (grant_if) begin
      req_owner <= OWN_FETCH;
      req_we    <= 1'b0;
      req_addr  <= if_addr;
      req_wdata <= '0;
    end
  end

  // Capture memory read data on the last WAIT cycle into the owner's register;
  // stores leave d_rdata untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (last_wait) begin
      if (req_owner == OWN_FETCH)  if_rdata_q <= m_rdata[31:0];
      else if (!req_we)            d_rdata_q  <= m_rdata;
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign m_en      = (state == ST_ISSUE);
  assign m_we      = (state != ST_IDLE) ? req_we    : 1'b0;
  assign m_addr    = (state != ST_IDLE) ? req_addr  : '0;
  assign m_wdata   = (state != ST_IDLE) ? req_wdata : '0;
  assign if_valid  = (state == ST_RESP) && (req_owner == OWN_FETCH);
  assign d_valid   = (state == ST_RESP) && (req_owner == OWN_DATA);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 15), each with
// its own stimulus, a transaction-level reference model and literal checks.
module tb_mem_port_arbiter;

  logic clk;
  int   errors = 0;
  int   checks = 0;
  bit   done_f [3];

  // Clock / reset block: clock shared, resets are per instance.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int lat, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (MEM_LAT=%0d) t=%0t got=%h expected=%h", nm, lat, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int LAT     = (g == 0) ? 1 : (g == 1) ? 2 : 15;
    // Hand-computed timing: request->valid, fetch grant after a data win,
    // and the data port's second grant in the tie sequence.
    localparam int EXP_VAL = (g == 0) ? 3 : (g == 1) ? 4 : 17;
    localparam int EXP_IG  = (g == 0) ? 4 : (g == 1) ? 5 : 18;
    localparam int EXP_DG1 = (g == 0) ? 8 : (g == 1) ? 10 : 36;

    logic        reset, if_req, if_gnt, if_valid, d_req, d_we, d_gnt, d_valid;
    logic        m_en, m_we, busy;
    logic [31:0] if_addr, if_rdata, d_addr, m_addr;
    logic [63:0] d_wdata, d_rdata, m_wdata, m_rdata;
    logic [1:0]  state_dbg;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .busy(busy), .state_dbg(state_dbg)
    );

    // Reference model: an access occupies the cycles grant+1 .. grant+LAT+2,
    // memory data is taken grant+LAT+1, the response pulses at grant+LAT+2.
    bit          act;
    int          k;
    bit          last_data;
    bit          t_data, t_we;
    logic [31:0] t_addr;
    logic [63:0] t_wdata;
    logic [31:0] exp_if_rd;
    logic [63:0] exp_d_rd;
    bit          pick_data;
    logic        e_if_gnt, e_d_gnt, e_m_en, e_m_we, e_if_v, e_d_v, e_busy;
    logic [31:0] e_m_addr;
    logic [63:0] e_m_wdata;

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
      e_if_gnt = 0; e_d_gnt = 0; e_m_en = 0; e_m_we = 0; e_if_v = 0; e_d_v = 0; e_busy = 0;
      e_m_addr = '0; e_m_wdata = '0; pick_data = 0;
      if (!reset) begin
        act = 0; k = 0; last_data = 0; exp_if_rd = '0; exp_d_rd = '0;
      end else if (!act) begin
        pick_data = (if_req && d_req) ? !last_data : d_req;
        if (if_req || d_req) begin
          e_if_gnt = !pick_data;
          e_d_gnt  = pick_data;
        end
      end else begin
        e_busy    = 1;
        e_m_en    = (k == 1);
        e_m_we    = t_we;
        e_m_addr  = t_addr;
        e_m_wdata = t_wdata;
        e_if_v    = (k == LAT + 2) && !t_data;
        e_d_v     = (k == LAT + 2) && t_data;
      end
      chk("if_gnt", LAT, if_gnt, e_if_gnt);
      chk("d_gnt", LAT, d_gnt, e_d_gnt);
      chk("m_en", LAT, m_en, e_m_en);
      chk("m_we", LAT, m_we, e_m_we);
      chk("m_addr", LAT, m_addr, e_m_addr);
      if (!act || t_data) chk("m_wdata", LAT, m_wdata, e_m_wdata);
      chk("if_valid", LAT, if_valid, e_if_v);
      chk("d_valid", LAT, d_valid, e_d_v);
      chk("busy", LAT, busy, e_busy);
      chk("if_rdata", LAT, if_rdata, exp_if_rd);
      chk("d_rdata", LAT, d_rdata, exp_d_rd);
      if (reset) begin
        if (!act && (if_req || d_req)) begin
          act = 1; k = 1; t_data = pick_data; last_data = pick_data;
          t_addr  = pick_data ? d_addr : if_addr;
          t_we    = pick_data ? d_we : 1'b0;
          t_wdata = pick_data ? d_wdata : 64'h0;
        end else if (act) begin
          if (k == LAT + 1) begin
            if (!t_data)    exp_if_rd = m_rdata[31:0];
            else if (!t_we) exp_d_rd  = m_rdata;
          end
          if (k == LAT + 2) act = 0;
          else k++;
        end
      end
    end

    // Driver task: one request from cycle start, observed for a fixed window.
    task automatic xfer(input bit is_d, input bit we, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] rd, output int gnt_dt, output int en_dt, output int val_dt,
                        output int en_n, output int oth_v, output logic en_we, output logic [31:0] en_addr,
                        output logic [63:0] en_wd);
      gnt_dt = -1; en_dt = -1; val_dt = -1; en_n = 0; oth_v = 0;
      en_we = 1'b0; en_addr = '0; en_wd = '0;
      m_rdata = rd;
      if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
      else begin if_req = 1; if_addr = addr; end
      for (int i = 0; i < LAT + 8; i++) begin
        @(negedge clk);
        if ((is_d ? d_gnt : if_gnt) && gnt_dt < 0) gnt_dt = i;
        if (m_en) begin
          en_n++;
          if (en_dt < 0) begin en_dt = i; en_we = m_we; en_addr = m_addr; en_wd = m_wdata; end
        end
        if ((is_d ? d_valid : if_valid) && val_dt < 0) val_dt = i;
        if (is_d ? if_valid : d_valid) oth_v++;
        @(posedge clk); #1;
        if (gnt_dt >= 0) begin d_req = 0; if_req = 0; end
      end
    endtask

    initial begin : drive
      int gdt, edt, vdt, en_n, ov, dg0, ig, dg1, nv, nen, nb, rst_hold;
      logic ewe;
      logic [31:0] ead;
      logic [63:0] ewd;
      bit ig_now, dg_now, ifp, dp;
      reset = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; m_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_busy", LAT, busy, 0);
      chk("rst_m_en", LAT, m_en, 0);
      chk("rst_d_rdata", LAT, d_rdata, 0);
      chk("rst_if_rdata", LAT, if_rdata, 0);
      @(posedge clk); #1;
      reset = 1;

      // Single load, issued in the first cycle after reset release.
      xfer(1, 0, 32'h100, 64'h0, 64'h1122334455667788, gdt, edt, vdt, en_n, ov, ewe, ead, ewd);
      chk("load_gnt_dt", LAT, gdt, 0);
      chk("load_en_dt", LAT, edt, 1);
      chk("load_val_dt", LAT, vdt, EXP_VAL);
      chk("load_addr", LAT, ead, 32'h100);
      chk("load_rdata", LAT, d_rdata, 64'h1122334455667788);

      // Store: data register must not pick up the bus value.
      xfer(1, 1, 32'h2000, 64'hDEADBEEF, 64'hFFFF0000FFFF0000, gdt, edt, vdt, en_n, ov, ewe, ead, ewd);
      chk("store_en_count", LAT, en_n, 1);
      chk("store_we", LAT, ewe, 1);
      chk("store_addr", LAT, ead, 32'h2000);
      chk("store_wdata", LAT, ewd, 64'hDEADBEEF);
      chk("store_val_dt", LAT, vdt, EXP_VAL);
      chk("store_rdata_hold", LAT, d_rdata, 64'h1122334455667788);

      // Fetch: low word only, data port stays quiet.
      xfer(0, 0, 32'h2000, 64'h0, 64'hAAAABBBB08000000, gdt, edt, vdt, en_n, ov, ewe, ead, ewd);
      chk("fetch_rdata", LAT, if_rdata, 32'h08000000);
      chk("fetch_d_valid", LAT, ov, 0);
      chk("fetch_val_dt", LAT, vdt, EXP_VAL);
      chk("fetch_d_rdata_hold", LAT, d_rdata, 64'h1122334455667788);

      // Tie after reset: data wins, fetch wins the next tie, data follows.
      reset = 0;
      @(posedge clk); #1;
      reset = 1;
      if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
      dg0 = -1; ig = -1; dg1 = -1;
      for (int i = 0; i < 3 * LAT + 14; i++) begin
        @(negedge clk);
        ig_now = if_gnt; dg_now = d_gnt;
        if (d_gnt) begin if (dg0 < 0) dg0 = i; else if (dg1 < 0) dg1 = i; end
        if (if_gnt && ig < 0) ig = i;
        @(posedge clk); #1;
        if (ig_now) if_req = 0;
        if (dg_now && dg1 >= 0) d_req = 0;
      end
      chk("tie_first_d", LAT, dg0, 0);
      chk("tie_if_gnt", LAT, ig, EXP_IG);
      chk("tie_second_d", LAT, dg1, EXP_DG1);

      // Reset during WAIT abandons the access.
      d_req = 1; d_we = 0; d_addr = 32'h300; m_rdata = 64'h5555666677778888;
      @(posedge clk); #1;
      d_req = 0;
      @(posedge clk); #1;
      reset = 0; if_req = 1;
      @(negedge clk);
      chk("midrst_busy", LAT, busy, 0);
      chk("midrst_m_addr", LAT, m_addr, 0);
      chk("midrst_d_rdata", LAT, d_rdata, 0);
      chk("midrst_if_rdata", LAT, if_rdata, 0);
      chk("midrst_if_gnt", LAT, if_gnt, 0);
      @(posedge clk); #1;
      if_req = 0;
      @(posedge clk); #1;
      reset = 1;
      nv = 0; nen = 0; nb = 0;
      repeat (LAT + 8) begin
        @(negedge clk);
        nv += int'(if_valid) + int'(d_valid); nen += int'(m_en); nb += int'(busy);
      end
      chk("postrst_valids", LAT, nv, 0);
      chk("postrst_m_en", LAT, nen, 0);
      chk("postrst_busy", LAT, nb, 0);
      @(posedge clk); #1;

      // Randomized traffic with occasional reset pulses.
      rst_hold = 0; ifp = 0; dp = 0;
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        ig_now = if_gnt; dg_now = d_gnt;
        @(posedge clk); #1;
        if (rst_hold > 0) begin
          rst_hold--;
          if (rst_hold == 0) reset = 1;
        end else if ($urandom_range(0, 249) == 0) begin
          reset = 0; rst_hold = $urandom_range(1, 3);
        end
        if (ifp && ig_now) begin ifp = 0; if_req = 0; end
        if (dp && dg_now) begin dp = 0; d_req = 0; end
        if (!ifp) begin
          if_addr = $urandom;
          if ($urandom_range(0, 2) == 0) begin ifp = 1; if_req = 1; end
        end
        if (!dp) begin
          d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = {$urandom, $urandom};
          if ($urandom_range(0, 2) == 0) begin dp = 1; d_req = 1; end
        end
        m_rdata = {$urandom, $urandom};
      end
      reset = 1; if_req = 0; d_req = 0;
      repeat (LAT + 6) @(posedge clk);
      done_f[g] = 1'b1;
    end
  end

  // Final report, bounded wait for all instances.
  initial begin : report
    int waited;
    waited = 0;
    while (!(done_f[0] && done_f[1] && done_f[2]) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    if (waited >= 20000) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for stimulus to complete got=%0d expected<%0d", waited, 20000);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: fixed memory read latency in cycles, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 if_req  input  1  instruction-fetch request; held high until granted.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_valid  output  1  one-cycle pulse: if_rdata is valid.
REQ-008 if_rdata  output  32  fetched instruction, equal to m_rdata[31:0].
REQ-009 d_req  input  1  data-access request; held high until granted.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  64  store data.
REQ-013 d_gnt  output  1  data request accepted this cycle.
REQ-014 d_valid  output  1  one-cycle pulse: load data valid, or store complete.
REQ-015 d_rdata  output  64  load data.
REQ-016 m_en  output  1  memory access strobe.
REQ-017 m_we  output  1  memory write enable, qualified by m_en.
REQ-018 m_addr  output  32  memory byte address.
REQ-019 m_wdata  output  64  memory write data.
REQ-020 m_rdata  input  64  memory read data, valid MEM_LAT cycles after the m_en cycle.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-023 Transition IDLE->ISSUE: taken when any request is high; otherwise the FSM stays in IDLE.
REQ-024 Transition ISSUE->WAIT: always taken after one cycle.
REQ-025 Transition WAIT->RESP: taken when the latency counter reaches MEM_LAT-1.
REQ-026 Transition RESP->IDLE: always taken after one cycle.
REQ-027 gnt timing: gnt is combinational and asserted only in IDLE; at most one of if_gnt and d_gnt is high in any cycle.
REQ-028 Arbitration when both requests are high: grant goes to the port not served last (round-robin); last_owner resets to FETCH, so data wins the first tie.
REQ-029 On gnt, the arbiter registers the owner, address, we and wdata; fetch requests register we=0.
REQ-030 Requester inputs are ignored in states other than IDLE.
REQ-031 m_en is high for exactly the ISSUE cycle, driven from the registered request.
REQ-032 m_we, m_addr and m_wdata hold their registered values from ISSUE through RESP and are 0 in IDLE.
REQ-033 Latency counter: cleared in ISSUE; increments each WAIT cycle; width sized for 15.
REQ-034 m_rdata is captured on the last WAIT cycle, i.e. MEM_LAT cycles after m_en.
REQ-035 Response pulse: the owner's valid pulses for the single RESP cycle.
REQ-036 Data hold: if_rdata/d_rdata change only on a load response of their own port and hold their value otherwise.
REQ-037 A store response pulses d_valid and leaves d_rdata unchanged.
REQ-038 Latency: request seen in IDLE at cycle 0 -> valid at cycle MEM_LAT+2; minimum spacing between grants is MEM_LAT+3 cycles.
REQ-039 Addresses pass through unmodified; no alignment check is performed.

Reset
REQ-040 While reset=0: FSM=IDLE, counter=0, last_owner=FETCH, and all outputs 0 (including if_rdata and d_rdata).
REQ-041 Reset asserted mid-operation abandons the access: no valid pulse is produced and m_en is not re-issued after release.
REQ-042 The first grant can occur in the first clock edge's cycle after reset deasserts.

Structure
REQ-043 Shared package tinker_mem_pkg SHALL hold: the state enum, the owner enum (FETCH, DATA), the MEM_LAT default, and the address/data width constants 32/64.
REQ-044 The block is flat, with no sub-module; arbitration and the counter are inline.

Verification
REQ-045 Single load: d_req=1, d_we=0, d_addr=0x100, m_rdata=0x1122334455667788, MEM_LAT=2 -> d_gnt at cycle 0, m_en at cycle 1, d_valid at cycle 4 with d_rdata=0x1122334455667788.
REQ-046 Tie after reset: if_req=d_req=1 -> d_gnt first; if_req held -> if_gnt at cycle 5; both held again -> data loses the next tie.
REQ-047 Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> m_en=m_we=1 with those values for one cycle; d_valid pulses; d_rdata unchanged.
REQ-048 Fetch: if_addr=0x2000, m_rdata=0xAAAA_BBBB_0800_0000 -> if_rdata=0x08000000; d_valid stays 0.
REQ-049 Reset mid-operation: reset=0 during WAIT -> all outputs 0 immediately; after release, no valid pulse and busy=0.
REQ-050 MEM_LAT=1 and MEM_LAT=15 builds: request-to-valid distance is 3 and 17 cycles respectively.
